ofs_plat_utils_ccip_byte_range_seq: RTL and testbench
=====================================================

Name: ofs_plat_utils_ccip_byte_range_seq

Overview:
- Sequences one multi-line byte-range write request (start line address, byte offset, byte length) into a stream of per-line beats, each with a 64-byte write mask.
- Sits in the CCI-P to Avalon/AXI write shims, ahead of the write-data merge.
- Computes the start index and the start-plus-length index for each line, then decodes them into a mask with the same semantics as the combinational start/end mask generator (which it may instantiate).
- Write data is not carried; the downstream merge pairs beats with data.

Parameters:
- ADDR_WIDTH, 42, line-address width (CCI-P line address).
- LEN_WIDTH, 12, width of the byte-length field; maximum request length is 2^LEN_WIDTH-1 bytes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  ADDR_WIDTH  line address of first line
- req_byte_start  in  6  byte offset within first line (t_ccip_clByteIdx)
- req_byte_len  in  LEN_WIDTH  total bytes in the range
- out_valid  out  1  beat valid
- out_ready  in  1  beat consumed when out_valid && out_ready
- out_addr  out  ADDR_WIDTH  line address of the beat
- out_bmask  out  64  byte mask for the beat; bit i = byte i
- out_sop  out  1  first beat of request
- out_eop  out  1  last beat of request
- busy  out  1  request in progress (state != IDLE)

Behaviour:
- One clock domain. Reset is synchronous and active-high on reset. On reset:
  - state=IDLE, out_valid=0, out_sop=0, out_eop=0, busy=0, req_ready=1 in the following cycle.
  - out_addr and out_bmask are reset to 0.
- Reset mid-request abandons the request immediately: no further beats, and nothing is held over.
- States are IDLE and BUSY.
- req_ready = (state==IDLE). There is exactly one request in flight, with no overlap.
- Acceptance in IDLE:
  - total = req_byte_start + req_byte_len, computed at LEN_WIDTH+1 bits with no truncation.
  - lines = (total + 63) >> 6.
  - If req_byte_len==0: the request is consumed and no beats are produced. State stays IDLE and req_ready stays 1.
  - Otherwise go to BUSY. First beat is valid the cycle after acceptance (latency 1):
    - out_addr = req_addr, out_sop = 1.
    - Mask start index = req_byte_start.
    - Mask end index = total[5:0] if lines==1, else 0.
- Mask rule:
  - Bits >= start index are set.
  - Bits < end index are set; an end index of 0 means "through byte 63".
  - bmask = start mask AND end mask.
- BUSY, on each out_valid && out_ready:
  - If out_eop: go to IDLE, out_valid=0 the next cycle. req_ready rises in that same next cycle, so there is a 1-cycle bubble between requests.
  - Else advance to the next beat:
    - out_addr += 1, modulo 2^ADDR_WIDTH (wraps silently).
    - out_sop = 0, start index = 0.
    - The remaining-line counter decrements.
    - out_eop = 1 when the remaining count reaches 1.
    - End index = total[5:0] on the last line, else 0.
- out_eop = 1 on the first beat when lines==1; out_sop and out_eop are then both set.
- While out_valid && !out_ready: out_addr, out_bmask, out_sop and out_eop are held stable.
- out_valid does not drop until the beat is accepted.
- req_* inputs are sampled only at acceptance; later changes to them are ignored.
- Arithmetic:
  - The remaining-line counter is LEN_WIDTH-5 bits, enough for a maximum of ceil((63+2^LEN_WIDTH-1)/64) lines.
  - total[5:0] is latched at acceptance.
- Outputs are registered; there is no combinational path from out_ready to out_valid.
- req_ready depends only on state.

Test Plan:
- Single-line range: start=10, len=20, addr=0x100, out_ready=1. Required: one beat at cycle+1, addr 0x100, bmask=0x0000_0000_3FFF_FC00, sop=1, eop=1. req_ready returns 1 two cycles after acceptance.
- Full line: start=0, len=64. Required: one beat, bmask=all ones, sop=eop=1.
- Line crossing: start=60, len=8, addr=0x7. Required:
  - Beat 0: addr 0x7, bmask=0xF000_0000_0000_0000, sop=1.
  - Beat 1: addr 0x8, bmask=0x0000_0000_0000_000F, eop=1.
- Four lines with backpressure: start=4, len=200, out_ready toggling 1,0,0,1,... Required:
  - 4 beats with bmasks 0xFFFF_FFFF_FFFF_FFF0, all ones, all ones, 0xFFF.
  - Outputs hold stable while out_ready=0; req_ready=0 throughout.
- Address wrap, zero length and reset:
  - addr=2^42-1, start=0, len=128 → addrs 2^42-1 then 0.
  - len=0 → no out_valid, req_ready stays 1.
  - reset asserted after beat 1 of a 4-beat request → out_valid=0 and busy=0 the next cycle. A new request is then accepted normally with sop=1.

Source files
------------

// File: rtl/ofs_plat_utils_ccip_byte_range_seq.sv
// ofs_plat_utils_ccip_byte_range_seq
//
// Purpose:
//   Turns one multi-line byte-range write request into a series of
//   per-line beats. Each beat carries a line address and a 64-byte write
//   mask. Write data is not carried here. The downstream merge stage pairs
//   each beat with its data.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   req_valid       request valid
//   req_ready       high while idle; the request is taken when valid && ready
//   req_addr        line address of the first line
//   req_byte_start  byte offset within the first line
//   req_byte_len    total number of bytes in the range
//   out_valid       beat valid
//   out_ready       beat consumed when out_valid && out_ready
//   out_addr        line address of the beat
//   out_bmask       byte mask for the beat (bit i = byte i)
//   out_sop         first beat of the request
//   out_eop         last beat of the request
//   busy            a request is in progress
module ofs_plat_utils_ccip_byte_range_seq #(
  parameter int ADDR_WIDTH = 42,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [5:0]            req_byte_start,
  input  logic [LEN_WIDTH-1:0]  req_byte_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [63:0]           out_bmask,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  busy
);

  // Width of the remaining-line counter. It holds up to
  // ceil((63 + 2^LEN_WIDTH - 1) / 64) lines.
  localparam int CNT_WIDTH = LEN_WIDTH - 5;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_next;
  logic                  out_valid_next;
  logic [ADDR_WIDTH-1:0] out_addr_next;
  logic [63:0]           out_bmask_next;
  logic                  out_sop_next;
  logic                  out_eop_next;
  logic [CNT_WIDTH-1:0]  remaining, remaining_next;
  logic [5:0]            end_last, end_last_next;

  logic [LEN_WIDTH:0]    total;
  logic [CNT_WIDTH-1:0]  req_lines;

  // Byte mask decode. Bytes at or above the start index are enabled.
  // Bytes below the end index are enabled, and an end index of 0 means
  // "through byte 63".
  function automatic logic [63:0] byte_mask(input logic [5:0] s,
                                            input logic [5:0] e);
    logic [63:0] sm;
    logic [63:0] em;
    sm = {64{1'b1}} << s;
    em = (e == 6'd0) ? {64{1'b1}} : ((64'd1 << e) - 64'd1);
    return sm & em;
  endfunction

  // The line count is written as the whole-line part plus one for a partial
  // tail. This equals (total + 63) >> 6 without a wider intermediate value.
  assign total     = {{(LEN_WIDTH-5){1'b0}}, req_byte_start} + {1'b0, req_byte_len};
  assign req_lines = total[LEN_WIDTH:6] + CNT_WIDTH'(total[5:0] != 6'd0);

  assign req_ready = (state == IDLE);
  assign busy      = (state == BUSY);

  // Next-state and next-beat logic. Every register holds its value unless
  // a request is accepted or a beat is consumed.
  always_comb begin
    state_next     = state;
    out_valid_next = out_valid;
    out_addr_next  = out_addr;
    out_bmask_next = out_bmask;
    out_sop_next   = out_sop;
    out_eop_next   = out_eop;
    remaining_next = remaining;
    end_last_next  = end_last;

    case (state)
      IDLE: begin
        if (req_valid && (req_byte_len != '0)) begin
          state_next     = BUSY;
          out_valid_next = 1'b1;
          out_addr_next  = req_addr;
          out_sop_next   = 1'b1;
          out_eop_next   = (req_lines == CNT_WIDTH'(1));
          out_bmask_next = byte_mask(req_byte_start,
                                     (req_lines == CNT_WIDTH'(1)) ? total[5:0] : 6'd0);
          remaining_next = req_lines;
          end_last_next  = total[5:0];
        end
      end
      BUSY: begin
        if (out_valid && out_ready) begin
          if (out_eop) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
            out_sop_next   = 1'b0;
            out_eop_next   = 1'b0;
          end else begin
            out_addr_next  = out_addr + ADDR_WIDTH'(1);
            out_sop_next   = 1'b0;
            remaining_next = remaining - CNT_WIDTH'(1);
            out_eop_next   = (remaining_next == CNT_WIDTH'(1));
            out_bmask_next = byte_mask(6'd0, out_eop_next ? end_last : 6'd0);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers. Reset drops any request in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_bmask <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      remaining <= '0;
      end_last  <= '0;
    end else begin
      state     <= state_next;
      out_valid <= out_valid_next;
      out_addr  <= out_addr_next;
      out_bmask <= out_bmask_next;
      out_sop   <= out_sop_next;
      out_eop   <= out_eop_next;
      remaining <= remaining_next;
      end_last  <= end_last_next;
    end
  end

endmodule

// File: tb/tb_ofs_plat_utils_ccip_byte_range_seq.sv
// tb_ofs_plat_utils_ccip_byte_range_seq
//
// Purpose:
//   Directed bench for the byte-range sequencer. Inputs change on the
//   falling edge and outputs are observed on the falling edge. The DUT
//   therefore samples on the rising edge midway between them.
//
// Ports: none (top-level bench).
module tb_ofs_plat_utils_ccip_byte_range_seq;

  localparam int ADDR_WIDTH = 42;
  localparam int LEN_WIDTH  = 12;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [5:0]            req_byte_start;
  logic [LEN_WIDTH-1:0]  req_byte_len;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [63:0]           out_bmask;
  logic                  out_sop;
  logic                  out_eop;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  logic [63:0] bp_masks [4];

  always #5 clk = ~clk;

  ofs_plat_utils_ccip_byte_range_seq #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_byte_start(req_byte_start),
    .req_byte_len  (req_byte_len),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_bmask     (out_bmask),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .busy          (busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [ADDR_WIDTH-1:0] addr,
                           input logic [63:0] mask, input logic sop, input logic eop);
    checkOutput({tag, ".valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, ".addr"},  64'(out_addr),  64'(addr));
    checkOutput({tag, ".bmask"}, out_bmask,      mask);
    checkOutput({tag, ".sop"},   64'(out_sop),   64'(sop));
    checkOutput({tag, ".eop"},   64'(out_eop),   64'(eop));
    checkOutput({tag, ".ready"}, 64'(req_ready), 64'd0);
    checkOutput({tag, ".busy"},  64'(busy),      64'd1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, ".ready"}, 64'(req_ready), 64'd1);
    checkOutput({tag, ".busy"},  64'(busy),      64'd0);
  endtask

  // Presents a request for one cycle, then scrambles the request fields so
  // that any late sampling by the DUT shows up.
  task automatic applyStimulus(input logic [ADDR_WIDTH-1:0] addr,
                               input logic [5:0] start,
                               input logic [LEN_WIDTH-1:0] len);
    req_addr       = addr;
    req_byte_start = start;
    req_byte_len   = len;
    req_valid      = 1'b1;
    @(negedge clk);
    req_valid      = 1'b0;
    req_addr       = '1;
    req_byte_start = 6'h2a;
    req_byte_len   = '1;
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_addr       = '0;
    req_byte_start = '0;
    req_byte_len   = '0;
    out_ready      = 1'b0;
    repeat (2) @(negedge clk);

    checkIdle("reset");
    checkOutput("reset.addr",  64'(out_addr),  64'd0);
    checkOutput("reset.bmask", out_bmask,      64'd0);
    checkOutput("reset.sop",   64'(out_sop),   64'd0);
    checkOutput("reset.eop",   64'(out_eop),   64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single line: bytes 10..29
    out_ready = 1'b1;
    applyStimulus(42'h100, 6'd10, 12'd20);
    checkBeat("single", 42'h100, 64'h0000_0000_3FFF_FC00, 1'b1, 1'b1);
    @(negedge clk);
    checkIdle("single.after");

    // Full line
    applyStimulus(42'h33, 6'd0, 12'd64);
    checkBeat("full", 42'h33, {64{1'b1}}, 1'b1, 1'b1);
    @(negedge clk);
    checkIdle("full.after");

    // Line crossing: bytes 60..67
    applyStimulus(42'h7, 6'd60, 12'd8);
    checkBeat("cross0", 42'h7, 64'hF000_0000_0000_0000, 1'b1, 1'b0);
    @(negedge clk);
    checkBeat("cross1", 42'h8, 64'h0000_0000_0000_000F, 1'b0, 1'b1);
    @(negedge clk);
    checkIdle("cross.after");

    // Four lines with backpressure: two stall cycles per beat
    bp_masks[0] = 64'hFFFF_FFFF_FFFF_FFF0;
    bp_masks[1] = {64{1'b1}};
    bp_masks[2] = {64{1'b1}};
    bp_masks[3] = 64'h0000_0000_0000_0FFF;
    out_ready = 1'b0;
    applyStimulus(42'h200, 6'd4, 12'd200);
    for (int i = 0; i < 4; i++) begin
      for (int h = 0; h < 3; h++) begin
        checkBeat($sformatf("bp%0d_%0d", i, h), ADDR_WIDTH'(32'h200 + i),
                  bp_masks[i], (i == 0), (i == 3));
        if (h < 2) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    checkIdle("bp.after");

    // Address wrap
    out_ready = 1'b1;
    applyStimulus({ADDR_WIDTH{1'b1}}, 6'd0, 12'd128);
    checkBeat("wrap0", {ADDR_WIDTH{1'b1}}, {64{1'b1}}, 1'b1, 1'b0);
    @(negedge clk);
    checkBeat("wrap1", '0, {64{1'b1}}, 1'b0, 1'b1);
    @(negedge clk);
    checkIdle("wrap.after");

    // Zero length: consumed with no beat
    applyStimulus(42'h55, 6'd5, 12'd0);
    checkIdle("zero0");
    @(negedge clk);
    checkIdle("zero1");

    // Reset in the middle of a four-beat request
    applyStimulus(42'h400, 6'd0, 12'd256);
    checkBeat("rst0", 42'h400, {64{1'b1}}, 1'b1, 1'b0);
    @(negedge clk);
    checkBeat("rst1", 42'h401, {64{1'b1}}, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkIdle("rst.after");
    @(negedge clk);
    checkIdle("rst.quiet");

    // Fresh request after reset: bytes 3..4
    applyStimulus(42'h55, 6'd3, 12'd2);
    checkBeat("post", 42'h55, 64'h0000_0000_0000_0018, 1'b1, 1'b1);
    @(negedge clk);
    checkIdle("post.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
